// File: rtl/iec_host_tx.sv
// Host-side IEC serial bus byte transmitter: sends command (ATN) and data bytes
// to listening drives with the CLK/DATA handshake, EOI signalling and timeouts.
module iec_host_tx #(
    parameter int unsigned CE_PER_US = 16,
    parameter int unsigned T_ATN_US  = 1000,
    parameter int unsigned T_NE_US   = 40,
    parameter int unsigned T_S_US    = 20,
    parameter int unsigned T_V_US    = 20,
    parameter int unsigned T_FA_US   = 1000,
    parameter int unsigned T_AR_US   = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_atn,
    input  logic       tx_eoi,
    input  logic       bus_release,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       iec_atn_i,
    input  logic       iec_clk_i,
    input  logic       iec_data_i,
    output logic       iec_atn_o,
    output logic       iec_clk_o,
    output logic       iec_data_o
);

    localparam int unsigned PRE_W = (CE_PER_US > 1) ? $clog2(CE_PER_US) : 1;
    localparam int unsigned US_W  = 16;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [3:0] {
        S_IDLE, S_ATN_WAIT, S_ATN_REL, S_READY, S_NE_WAIT, S_EOI_LO,
        S_EOI_HI, S_BIT_S, S_BIT_V, S_FRAME_ACK, S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [US_W-1:0]    us_q, us_d;
    logic [7:0]         data_q, data_d;
    logic               eoi_q, eoi_d;
    logic               pending_q, pending_d;
    logic               atn_held_q, atn_held_d;
    logic               clk_held_q, clk_held_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               tx_ready_q, tx_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               atn_o_q, atn_o_d;
    logic               clk_o_q, clk_o_d;
    logic               data_o_q, data_o_d;

    logic               us_tick_c;
    logic [US_W-1:0]    us_next_c;
    logic               accept_c;
    logic               unused_bus_c;

    // The initiator never needs to observe ATN or CLK; only DATA carries replies.
    assign unused_bus_c = &{iec_atn_i, iec_clk_i};

    // A release or abort arriving with a request wins, so acceptance is withheld that cycle.
    assign tx_ready = tx_ready_q & ~bus_release & ~abort;
    assign accept_c = tx_valid & tx_ready;

    // Microsecond timebase; a wait of T expires on the tick that brings the count to T.
    assign us_tick_c = ce && (pre_q == PRE_W'(CE_PER_US - 1));
    assign us_next_c = us_q + US_W'(us_tick_c);

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign iec_atn_o  = atn_o_q;
    assign iec_clk_o  = clk_o_q;
    assign iec_data_o = data_o_q;

    // Next-state, timer and registered-output computation.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        eoi_d      = eoi_q;
        pending_d  = pending_q;
        atn_held_d = atn_held_q;
        clk_held_d = clk_held_q;
        idx_d      = idx_q;
        err_code_d = err_code_q;
        done_d     = 1'b0;
        pre_d      = ce ? (us_tick_c ? '0 : pre_q + PRE_W'(1)) : pre_q;
        us_d       = us_next_c;

        case (state_q)
            S_IDLE: begin
                if (bus_release) begin
                    if (atn_held_q) state_d = S_ATN_REL;
                    else            clk_held_d = 1'b0;
                end else if (accept_c) begin
                    data_d     = tx_data;
                    eoi_d      = tx_eoi;
                    pending_d  = 1'b1;
                    err_code_d = 2'd0;
                    if (tx_atn && !atn_held_q) begin
                        atn_held_d = 1'b1;
                        clk_held_d = 1'b1;
                        state_d    = S_ATN_WAIT;
                    end else if (!tx_atn && atn_held_q) begin
                        state_d = S_ATN_REL;
                    end else begin
                        state_d = S_READY;
                    end
                end
            end
            S_ATN_WAIT: begin
                if (!iec_data_i) begin
                    state_d = S_READY;
                end else if (us_next_c == US_W'(T_ATN_US)) begin
                    state_d    = S_ERROR;
                    err_code_d = 2'd1;
                end
            end
            S_ATN_REL: begin
                if (us_next_c == US_W'(T_AR_US)) begin
                    if (pending_q) begin
                        state_d = S_READY;
                    end else begin
                        clk_held_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_READY: begin
                if (iec_data_i) state_d = eoi_q ? S_EOI_LO : S_NE_WAIT;
            end
            S_NE_WAIT: begin
                if (us_next_c == US_W'(T_NE_US)) begin
                    state_d = S_BIT_S;
                    idx_d   = '0;
                end
            end
            S_EOI_LO: begin
                if (!iec_data_i) state_d = S_EOI_HI;
            end
            S_EOI_HI: begin
                if (iec_data_i) begin
                    state_d = S_BIT_S;
                    idx_d   = '0;
                end
            end
            S_BIT_S: begin
                if (us_next_c == US_W'(T_S_US)) state_d = S_BIT_V;
            end
            S_BIT_V: begin
                if (us_next_c == US_W'(T_V_US)) begin
                    if (idx_q == IDX_W'(7)) begin
                        state_d    = S_FRAME_ACK;
                        clk_held_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_BIT_S;
                    end
                end
            end
            S_FRAME_ACK: begin
                if (!iec_data_i) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (us_next_c == US_W'(T_FA_US)) begin
                    state_d    = S_ERROR;
                    err_code_d = 2'd2;
                end
            end
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_ATN_REL || state_d == S_ERROR) atn_held_d = 1'b0;
        if (state_d == S_ERROR)                         clk_held_d = 1'b0;

        if (abort) begin
            state_d    = S_IDLE;
            atn_held_d = 1'b0;
            clk_held_d = 1'b0;
            done_d     = 1'b0;
            pre_d      = '0;
            us_d       = '0;
        end

        if (state_d != state_q) begin
            pre_d = '0;
            us_d  = '0;
        end
        if (state_d == S_IDLE) pending_d = 1'b0;

        tx_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        err_d      = (state_d == S_ERROR);
        atn_o_d    = ~atn_held_d;

        case (state_d)
            S_IDLE, S_ATN_REL:                clk_o_d = ~clk_held_d;
            S_ATN_WAIT, S_BIT_S, S_FRAME_ACK: clk_o_d = 1'b0;
            default:                          clk_o_d = 1'b1;
        endcase

        data_o_d = (state_d == S_BIT_S || state_d == S_BIT_V) ? data_q[idx_d] : 1'b1;
    end

    // State and output registers; reset releases every bus line at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pre_q      <= '0;
            us_q       <= '0;
            data_q     <= '0;
            eoi_q      <= 1'b0;
            pending_q  <= 1'b0;
            atn_held_q <= 1'b0;
            clk_held_q <= 1'b0;
            idx_q      <= '0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            atn_o_q    <= 1'b1;
            clk_o_q    <= 1'b1;
            data_o_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            us_q       <= us_d;
            data_q     <= data_d;
            eoi_q      <= eoi_d;
            pending_q  <= pending_d;
            atn_held_q <= atn_held_d;
            clk_held_q <= clk_held_d;
            idx_q      <= idx_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            atn_o_q    <= atn_o_d;
            clk_o_q    <= clk_o_d;
            data_o_q   <= data_o_d;
        end
    end

endmodule

// File: tb/tb_iec_host_tx.sv
// Directed bench for iec_host_tx: a listener model on a wired-AND bus, a bit
// monitor that rebuilds each byte from CLK-release edges, and a byte scoreboard.
`timescale 1ns/1ps
module tb_iec_host_tx;

    localparam int SIG_CLK  = 0;
    localparam int SIG_ERR  = 1;
    localparam int SIG_DONE = 2;

    logic       clk = 1'b0;
    logic       reset_n, ce, tx_valid, tx_atn, tx_eoi, bus_release, abort;
    logic [7:0] tx_data;
    logic       tx_ready, busy, done, err;
    logic [1:0] err_code;
    logic       iec_atn_o, iec_clk_o, iec_data_o;
    logic       bus_atn, bus_clk, bus_data;
    logic       lst_data;
    logic       listening;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    // monitor state
    int         mon_cyc  = 0;
    logic       prev_clk = 1'b1;
    int         bit_cnt  = 0;
    logic [7:0] sh       = 8'h00;
    int         rise_cyc = 0;
    int         vmin     = 32'h7fffffff;
    int         vmax     = 0;
    logic [7:0] rx_byte  = 8'h00;
    int         rx_count = 0;

    assign bus_atn  = iec_atn_o;
    assign bus_clk  = iec_clk_o;
    assign bus_data = iec_data_o & lst_data;

    iec_host_tx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_atn      (tx_atn),
        .tx_eoi      (tx_eoi),
        .bus_release (bus_release),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .iec_atn_i   (bus_atn),
        .iec_clk_i   (bus_clk),
        .iec_data_i  (bus_data),
        .iec_atn_o   (iec_atn_o),
        .iec_clk_o   (iec_clk_o),
        .iec_data_o  (iec_data_o)
    );

    always #5 clk = ~clk;

    // Listener-side view: DATA sampled on each CLK release, LSB first; valid-time widths recorded.
    always @(posedge clk) begin
        mon_cyc  <= mon_cyc + 1;
        prev_clk <= bus_clk;
        if (!listening) begin
            bit_cnt <= 0;
            vmin    <= 32'h7fffffff;
            vmax    <= 0;
        end else begin
            if (!prev_clk && bus_clk && bit_cnt < 8) begin
                sh       <= {bus_data, sh[7:1]};
                rise_cyc <= mon_cyc;
                bit_cnt  <= bit_cnt + 1;
                if (bit_cnt == 7) begin
                    rx_byte  <= {bus_data, sh[7:1]};
                    rx_count <= rx_count + 1;
                end
            end
            if (prev_clk && !bus_clk && bit_cnt != 0) begin
                if (mon_cyc - rise_cyc < vmin) vmin <= mon_cyc - rise_cyc;
                if (mon_cyc - rise_cyc > vmax) vmax <= mon_cyc - rise_cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SIG_CLK: return iec_clk_o;
            SIG_ERR: return err;
            default: return done;
        endcase
    endfunction

    // Step at least one cycle, then until the selected output reaches val; k = cycles stepped.
    task automatic wait_sig(input int sel, input logic val, input int limit,
                            input string tag, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (sig(sel) !== val && k < limit);
        vectors++;
        assert (sig(sel) === val) else begin
            miscompares++;
            $error("FAIL %s: observed level %b after %0d cycles, expected %b", tag, sig(sel), k, val);
        end
    endtask

    // Present one request; returns one cycle after the accepting edge.
    task automatic send(input logic [7:0] d, input logic atn, input logic eoi);
        tx_data  = d;
        tx_atn   = atn;
        tx_eoi   = eoi;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Wait for the monitor to finish a byte, score it, then wait for the frame-ack CLK pull.
    task automatic wait_byte(input string tag);
        int seen;
        int k;
        logic [7:0] e;
        seen = rx_count;
        k    = 0;
        while (rx_count == seen && k < 8000) begin
            tick(1);
            k++;
        end
        vectors++;
        assert (rx_count != seen) else begin
            miscompares++;
            $error("FAIL %s_rx: observed no byte after %0d cycles, expected one", tag, k);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        chk({tag, "_byte"}, 32'(rx_byte), 32'(e));
        wait_sig(SIG_CLK, 1'b0, 400, {tag, "_frame"}, k);
    endtask

    task automatic chk_valid_time(input string tag);
        chk({tag, "_tv_min"}, 32'(vmin), 32'd320);
        chk({tag, "_tv_max"}, 32'(vmax), 32'd320);
    endtask

    initial begin
        int k;
        reset_n = 1'b0; ce = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_atn = 1'b0;
        tx_eoi = 1'b0; bus_release = 1'b0; abort = 1'b0; lst_data = 1'b1; listening = 1'b0;
        tick(3);
        chk("rst_lines", 32'({iec_atn_o, iec_clk_o, iec_data_o}), 32'b111);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({done, err, err_code}), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // ATN command with no device present: error code 1 after 1000 us
        send(8'h28, 1'b1, 1'b0);
        chk("nodev_atn_clk_low", 32'({iec_atn_o, iec_clk_o}), 32'b00);
        wait_sig(SIG_ERR, 1'b1, 20000, "nodev_err", k);
        chk("nodev_err_time", 32'(k), 32'd16000);
        chk("nodev_code", 32'(err_code), 32'd1);
        chk("nodev_lines", 32'({iec_atn_o, iec_clk_o, iec_data_o}), 32'b111);
        tick(1);
        chk("nodev_err_pulse", 32'({err, busy}), 32'b00);

        // ATN command 0x28, device answers 100 us after ATN
        exp_q.push_back(8'h28);
        send(8'h28, 1'b1, 1'b0);
        chk("cmd_atn_clk_low", 32'({iec_atn_o, iec_clk_o}), 32'b00);
        chk("cmd_code_clear", 32'(err_code), 32'd0);
        tick(1599);
        lst_data = 1'b0;
        tick(1);
        chk("cmd_ready_lines", 32'({iec_atn_o, iec_clk_o}), 32'b01);
        tick(800);
        listening = 1'b1;
        lst_data  = 1'b1;
        // one cycle for the handshake sample plus 40 us
        wait_sig(SIG_CLK, 1'b0, 2000, "cmd_ne", k);
        chk("cmd_ne_time", 32'(k), 32'd641);
        wait_byte("cmd");
        tick(100);
        lst_data = 1'b0;
        wait_sig(SIG_DONE, 1'b1, 10, "cmd_done", k);
        chk("cmd_done_lat", 32'(k), 32'd1);
        chk("cmd_held_lines", 32'({iec_atn_o, iec_clk_o, iec_data_o}), 32'b001);
        chk("cmd_idle", 32'({busy, tx_ready}), 32'b01);
        chk_valid_time("cmd");
        listening = 1'b0;
        tick(1);
        chk("cmd_done_pulse", 32'(done), 32'd0);

        // Data byte 0x55 after the command: ATN release, 20 us hold, then ready phase
        exp_q.push_back(8'h55);
        send(8'h55, 1'b0, 1'b0);
        chk("dat_atn_rel", 32'({iec_atn_o, iec_clk_o}), 32'b10);
        wait_sig(SIG_CLK, 1'b1, 1000, "dat_ar", k);
        chk("dat_ar_time", 32'(k), 32'd320);
        tick(480);
        listening = 1'b1;
        lst_data  = 1'b1;
        wait_sig(SIG_CLK, 1'b0, 2000, "dat_ne", k);
        chk("dat_ne_time", 32'(k), 32'd641);
        wait_byte("dat");
        tick(50);
        lst_data = 1'b0;
        wait_sig(SIG_DONE, 1'b1, 10, "dat_done", k);
        chk("dat_held_lines", 32'({iec_atn_o, iec_clk_o}), 32'b10);
        chk_valid_time("dat");
        listening = 1'b0;
        tick(1);

        // bus_release together with a request: release wins, clk_held clears
        bus_release = 1'b1;
        tx_valid    = 1'b1;
        tx_data     = 8'h99;
        #1;
        chk("rel_ready_low", 32'(tx_ready), 32'd0);
        tick(1);
        bus_release = 1'b0;
        tx_valid    = 1'b0;
        chk("rel_not_accepted", 32'(busy), 32'd0);
        chk("rel_clk_free", 32'(iec_clk_o), 32'd1);

        // EOI byte: listener acks EOI 250 us into the wait, for 60 us
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b0, 1'b1);
        tick(100);
        listening = 1'b1;
        lst_data  = 1'b1;
        tick(4000);
        lst_data = 1'b0;
        tick(960);
        chk("eoi_no_bits", 32'({iec_clk_o, iec_data_o}), 32'b11);
        lst_data = 1'b1;
        wait_sig(SIG_CLK, 1'b0, 10, "eoi_start", k);
        chk("eoi_start_lat", 32'(k), 32'd1);
        wait_byte("eoi");
        tick(20);
        lst_data = 1'b0;
        wait_sig(SIG_DONE, 1'b1, 10, "eoi_done", k);
        chk_valid_time("eoi");
        listening = 1'b0;
        tick(1);

        // Byte with a 100-cycle ce gap in NE_WAIT, then no frame ack: code 2
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b0, 1'b0);
        tick(10);
        listening = 1'b1;
        lst_data  = 1'b1;
        tick(10);
        ce = 1'b0;
        tick(100);
        ce = 1'b1;
        // 641 cycles plus 100 frozen, 110 already elapsed
        wait_sig(SIG_CLK, 1'b0, 2000, "fa_ne", k);
        chk("fa_ne_frozen_time", 32'(k), 32'd631);
        wait_byte("fa");
        wait_sig(SIG_ERR, 1'b1, 17000, "fa_err", k);
        chk("fa_err_time", 32'(k), 32'd16000);
        chk("fa_code", 32'(err_code), 32'd2);
        chk("fa_lines", 32'({iec_atn_o, iec_clk_o, iec_data_o}), 32'b111);
        chk_valid_time("fa");
        listening = 1'b0;
        tick(2);

        // Abort during bit 3
        listening = 1'b1;
        send(8'hF0, 1'b0, 1'b0);
        chk("abt_code_clear", 32'(err_code), 32'd0);
        k = 0;
        while (bit_cnt < 3 && k < 5000) begin
            tick(1);
            k++;
        end
        chk("abt_bits_seen", 32'(bit_cnt), 32'd3);
        wait_sig(SIG_CLK, 1'b0, 400, "abt_bit3", k);
        chk("abt_bit3_data", 32'(iec_data_o), 32'd0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        #1;
        chk("abt_lines", 32'({iec_atn_o, iec_clk_o, iec_data_o}), 32'b111);
        chk("abt_state", 32'({busy, tx_ready, err}), 32'b010);
        listening = 1'b0;
        tick(2);

        // Asynchronous reset during BIT_V
        listening = 1'b1;
        send(8'h00, 1'b0, 1'b0);
        k = 0;
        while (bit_cnt < 1 && k < 2000) begin
            tick(1);
            k++;
        end
        chk("rv_in_bit_v", 32'({iec_clk_o, iec_data_o}), 32'b10);
        reset_n = 1'b0;
        #1;
        chk("rv_lines", 32'({iec_atn_o, iec_clk_o, iec_data_o}), 32'b111);
        chk("rv_state", 32'({busy, tx_ready}), 32'b01);
        tick(2);
        reset_n   = 1'b1;
        listening = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
